// File: rtl/tagged_ram_ctl.sv
// tagged_ram_ctl: tagged main-memory slave with pipelined reads, wrapping bursts, optional parity (TAGRAM_PARITY_EN)
module tagged_ram_ctl #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int RD_LAT    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_ad,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_astb,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              i_wrap,
  input  logic              i_pinj,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_perr
);
  localparam int DT_W = DATA_W + TAG_W;
`ifdef TAGRAM_PARITY_EN
  localparam int W = DT_W + 1;
`else
  localparam int W = DT_W;
`endif
  localparam logic [ADDR_W-1:0] BMASK = ADDR_W'(BURST_LEN - 1);
  logic [W-1:0]      mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] waddr, inc, nxt;
  logic              do_wr, do_rd, err_set;
  logic [W-1:0]      wdat, rword;
  logic              rperr;
  logic [RD_LAT-1:0] pv, pe;
  logic [DT_W-1:0]   pd [RD_LAT];
  assign do_wr   = i_wr & ~i_astb;
  assign do_rd   = i_rd & ~i_wr & ~i_astb;
  assign err_set = i_rd & i_wr & ~i_astb;
  assign inc     = waddr + 1'b1;
  assign nxt     = i_wrap ? (waddr & ~BMASK) | (inc & BMASK) : inc;
  assign rword   = mem[waddr];
`ifdef TAGRAM_PARITY_EN
  assign wdat  = {^{i_ad, i_tag} ^ i_pinj, i_tag, i_ad};
  assign rperr = rword[W-1] != ^rword[DT_W-1:0];
`else
  logic unused_pinj;
  assign unused_pinj = i_pinj;
  assign wdat  = {i_tag, i_ad};
  assign rperr = 1'b0;
`endif
  // array write port; contents survive reset
  always_ff @(posedge clk)
    if (!reset && do_wr) mem[waddr] <= wdat;
  // address register, sticky error and first read stage
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr <= '0;
      o_err <= 1'b0;
      pv[0] <= 1'b0;
      pe[0] <= 1'b0;
      pd[0] <= '0;
    end else begin
      if (i_astb) waddr <= i_ad[ADDR_W-1:0];
      else if (do_wr || do_rd) waddr <= nxt;
      o_err <= o_err | err_set;
      pv[0] <= do_rd;
      pe[0] <= do_rd & rperr;
      if (do_rd) pd[0] <= rword[DT_W-1:0];
    end
  end
  // remaining read stages; data only moves with a valid so the outputs hold
  for (genvar k = 1; k < RD_LAT; k++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (reset) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= '0;
      end else begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end
  assign o_valid         = pv[RD_LAT-1];
  assign o_perr          = pe[RD_LAT-1];
  assign {o_tag, o_data} = pd[RD_LAT-1];
endmodule
